rr_packet_arbiter: RTL and testbench
====================================

# rr_packet_arbiter

Parametrised round-robin arbiter with packet-level grant locking for the NoC switch output ports. Picks one of `IN_N` competing inputs using a rotating priority pointer, holds the grant until the granted packet's tail has passed (`release_i`), then advances the pointer past the winner for fairness. It replaces fixed-priority selection in the switch allocator. Static priority survives only as the rotation tie-break order inside one cycle.

## Interface
Parameters:
- `IN_N`, 5, number of requesting inputs; legal range 2..16.
- `WDOG_CYC`, 16, watchdog limit in cycles; used only with `RR_ARB_WATCHDOG_EN`; ≥2.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  IN_N  per-input request; bit i = input i has a flit waiting for this output.
- `release_i`  in  1  tail flit of granted packet transferred this cycle; ignored when no grant.
- `grant_valid_o`  out  1  a grant is held.
- `grant_o`  out  $clog2(IN_N)  binary index of granted input; 0 when `grant_valid_o`=0.
- `grant_oh_o`  out  IN_N  one-hot grant; all zero when `grant_valid_o`=0.
- `wdog_o`  out  1  one-cycle pulse on forced release; tied 0 without `RR_ARB_WATCHDOG_EN`.

Clock and reset: one clock; reset is asynchronous and active-low.

## Operation
- State machine has two states: IDLE and LOCKED.
  - IDLE: if `req_i`≠0, pick the winner, register it, and go to LOCKED.
  - LOCKED: hold the grant. If `release_i`=1: set ptr = (grant+1) mod IN_N. Re-arbitrate in the same cycle over `req_i` with the updated ptr, with the releasing input's bit masked.
    - If a winner exists, stay LOCKED with the new grant.
    - Otherwise go to IDLE.
- Pick rule: the first set bit of `req_i` scanning upward from ptr, wrapping at IN_N-1 → 0. This is a rotated carry-chain; the lowest index wins relative to ptr.
- The pointer updates only on release, never on grant. A packet that is never released keeps ptr frozen.
- If `req_i[grant]` drops while LOCKED without `release_i`, this is a protocol violation and the grant is still held. The watchdog covers this case if it is compiled in.
- The masked re-pick on release means one input cannot win twice in a row while others wait. If only the releasing input is requesting, go to IDLE; it wins next cycle.
- No output is combinational from `req_i` or `release_i`; all outputs come from flops.

## Timing
- Reset values: state=IDLE, ptr=0, `grant_valid_o`=0, `grant_o`=0, `grant_oh_o`=0, `wdog_o`=0. Reset mid-packet drops the grant immediately and asynchronously.
- Request → grant latency: 1 cycle. A request at edge n is granted at edge n+1.
- Release → next grant: 0 bubble cycles. The new grant is visible at the edge after the `release_i` cycle.
- `release_i` while IDLE: ignored; no pointer change.
- Simultaneous requests: resolved purely by ptr rotation, within a single cycle.
- ptr wrap: a grant of IN_N-1 released sets ptr to 0.

## Configuration
- `RR_ARB_WATCHDOG_EN` defined:
  - A counter of width $clog2(WDOG_CYC+1) counts consecutive LOCKED cycles with `req_i[grant]`=0 and `release_i`=0.
  - The counter clears on any cycle where req is present, on release, and on a new grant.
  - On reaching `WDOG_CYC`, the block acts exactly as if `release_i`=1 that cycle (pointer advance and masked re-pick) and pulses `wdog_o` for 1 cycle.
- `RR_ARB_WATCHDOG_EN` undefined: no counter, `wdog_o`=0 constantly, and a dropped request holds the grant indefinitely.

## Structure
- Shared package `arb_pkg` holds:
  - state enum `arb_state_t` {ARB_IDLE, ARB_LOCKED};
  - function `arb_idx_w(n)` returning $clog2(n), for index widths.
- Sub-module `rr_priority_pick`: purely combinational. Takes `req`, `ptr` and `mask`, and outputs `hit`, `idx` and `oh`. It is implemented as rotate, carry-chain first-one, and rotate back. The arbiter instantiates it once, feeding it the next-ptr on release and the current ptr otherwise.

## Test plan
- Reset, then `req_i`=5'b10100 → after 1 cycle grant_o=2, grant_oh_o=5'b00100, ptr stays 0 until release.
- All 5 requesting continuously, release every 3rd locked cycle → grant sequence 0,1,2,3,4,0 with no idle cycle between grants.
- Grant 4 with req_i=5'b10000 only, then release → IDLE for 1 cycle, then grant 4 again, ptr=0.
- Assert `rst_ni`=0 mid-packet while grant=3 → outputs zero asynchronously; after reset, req_i=5'b01000 → grant 3.
- `release_i`=1 while IDLE with req_i=0 → no state or ptr change; the next request at input 1 is granted with ptr=0.
- With `RR_ARB_WATCHDOG_EN`, WDOG_CYC=4: grant 1, drop req_i[1], other req_i[2]=1 → after 4 cycles `wdog_o` pulses, grant_o=2 on the next edge. Without the macro → grant 1 held for 50 cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter.
//   arb_state_t : arbiter FSM state (idle / grant locked to a packet)
//   arb_idx_w   : width of a binary index into n requesters
package arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int unsigned arb_idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Request/grant bundle between an output port's requesters and its arbiter.
//   req_i         : per-input request
//   release_i     : tail flit of the granted packet moved this cycle
//   grant_valid_o : a grant is held
//   grant_o       : binary index of the granted input (0 when idle)
//   grant_oh_o    : one-hot grant (0 when idle)
//   wdog_o        : one-cycle pulse on a watchdog-forced release
// master = requester side, slave = arbiter side.
interface rr_packet_arbiter_if #(
  parameter int unsigned IN_N = 5
) ();

  localparam int unsigned IDX_W = arb_pkg::arb_idx_w(IN_N);

  logic [IN_N-1:0]  req_i;
  logic             release_i;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_o;
  logic [IN_N-1:0]  grant_oh_o;
  logic             wdog_o;

  modport master (
    output req_i, release_i,
    input  grant_valid_o, grant_o, grant_oh_o, wdog_o
  );

  modport slave (
    input  req_i, release_i,
    output grant_valid_o, grant_o, grant_oh_o, wdog_o
  );

endinterface

// File: rtl/rr_packet_arbiter_pick.sv
// rr_priority_pick: combinational rotating-priority first-one picker.
//   req  : candidate requests
//   ptr  : highest-priority index this cycle
//   mask : requests excluded from this pick
//   hit  : some unmasked request exists
//   idx  : binary index of the winner (first set bit at/after ptr, wrapping)
//   oh   : one-hot winner
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]              req,
  input  logic [arb_idx_w(N)-1:0]   ptr,
  input  logic [N-1:0]              mask,
  output logic                      hit,
  output logic [arb_idx_w(N)-1:0]   idx,
  output logic [N-1:0]              oh
);

  localparam int unsigned IDX_W = arb_idx_w(N);

  logic [N-1:0]   cand;
  logic [N-1:0]   rot;
  logic [N-1:0]   first;
  logic [2*N-1:0] rot_w;
  logic [2*N-1:0] back_w;

  assign cand  = req & ~mask;
  assign hit   = |cand;

  // Rotate so ptr lands on bit 0, isolate lowest set bit, rotate back.
  assign rot_w  = {cand, cand} >> ptr;
  assign rot    = rot_w[N-1:0];
  assign first  = rot & (~rot + N'(1));
  assign back_w = {first, first} << ptr;
  assign oh     = back_w[2*N-1:N];

  // One-hot to binary.
  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: round-robin output-port arbiter with packet-level grant
// locking. The grant is held until release_i (tail flit), then the pointer
// moves past the winner and the remaining requesters are re-arbitrated in
// the same cycle with the releasing input masked.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   arb    : rr_packet_arbiter_if.slave (req/release in, grant/wdog out)
// Optional feature macro: RR_ARB_WATCHDOG_EN - forces a release after
// WDOG_CYC consecutive locked cycles with the granted request dropped.
module rr_packet_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned IN_N     = 5,
  parameter int unsigned WDOG_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rr_packet_arbiter_if.slave   arb
);

  localparam int unsigned IDX_W = arb_idx_w(IN_N);

  if (IN_N < 2 || IN_N > 16 || WDOG_CYC < 2) begin : g_bad_param
    $error("rr_packet_arbiter: IN_N must be 2..16 and WDOG_CYC >= 2");
  end

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IN_N-1:0]  grant_oh_q, grant_oh_d;
  logic             grant_valid_q, grant_valid_d;

  logic             wdog_fire;
  logic             rel_eff;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] pick_ptr;
  logic [IN_N-1:0]  pick_mask;
  logic             pick_hit;
  logic [IDX_W-1:0] pick_idx;
  logic [IN_N-1:0]  pick_oh;

  // Release is only meaningful while a grant is held.
  assign rel_eff   = (state_q == ARB_LOCKED) && (arb.release_i || wdog_fire);
  assign next_ptr  = (grant_q == IDX_W'(IN_N - 1)) ? '0 : grant_q + IDX_W'(1);
  assign pick_ptr  = rel_eff ? next_ptr : ptr_q;
  assign pick_mask = rel_eff ? grant_oh_q : '0;

  rr_priority_pick #(
    .N (IN_N)
  ) u_pick (
    .req  (arb.req_i),
    .ptr  (pick_ptr),
    .mask (pick_mask),
    .hit  (pick_hit),
    .idx  (pick_idx),
    .oh   (pick_oh)
  );

  // Next-state and grant logic.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    grant_oh_d    = grant_oh_q;
    grant_valid_d = grant_valid_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_hit) begin
          state_d       = ARB_LOCKED;
          grant_d       = pick_idx;
          grant_oh_d    = pick_oh;
          grant_valid_d = 1'b1;
        end
      end
      ARB_LOCKED: begin
        if (rel_eff) begin
          ptr_d = next_ptr;
          if (pick_hit) begin
            grant_d    = pick_idx;
            grant_oh_d = pick_oh;
          end else begin
            state_d       = ARB_IDLE;
            grant_d       = '0;
            grant_oh_d    = '0;
            grant_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        grant_oh_d    = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= '0;
      grant_q       <= '0;
      grant_oh_q    <= '0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_q       <= grant_d;
      grant_oh_q    <= grant_oh_d;
      grant_valid_q <= grant_valid_d;
    end
  end

  assign arb.grant_valid_o = grant_valid_q;
  assign arb.grant_o       = grant_q;
  assign arb.grant_oh_o    = grant_oh_q;

`ifdef RR_ARB_WATCHDOG_EN
  localparam int unsigned CNT_W = $clog2(WDOG_CYC + 1);

  logic [CNT_W-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_q, wdog_d;
  logic             dropped;

  // Fires on the WDOG_CYC-th consecutive stalled cycle and acts as a release.
  assign dropped   = (state_q == ARB_LOCKED) && !(|(arb.req_i & grant_oh_q)) &&
                     !arb.release_i;
  assign wdog_fire = dropped && (wdog_cnt_q == CNT_W'(WDOG_CYC - 1));

  always_comb begin
    wdog_cnt_d = '0;
    wdog_d     = wdog_fire;
    if (dropped && !wdog_fire) wdog_cnt_d = wdog_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  assign arb.wdog_o = wdog_q;
`else
  assign wdog_fire  = 1'b0;
  assign arb.wdog_o = 1'b0;
`endif

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Self-checking bench for rr_packet_arbiter: directed scenarios plus random
// request/release traffic, compared cycle by cycle against a queue-free
// behavioural model of the round-robin locking rules.
module tb_rr_packet_arbiter;

  localparam int unsigned N    = 5;
  localparam int unsigned WDOG = 4;

  logic clk;
  logic rst_n;

  rr_packet_arbiter_if #(.IN_N(N)) bus ();

  rr_packet_arbiter #(
    .IN_N     (N),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .arb    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_err;

  // Reference model state
  bit m_locked;
  int m_ptr;
  int m_grant;
  int m_cnt;
  bit m_wdog;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] req, input int p, input int excl);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (p + k) % N;
      if (req[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_locked = 0;
    m_ptr    = 0;
    m_grant  = 0;
    m_cnt    = 0;
    m_wdog   = 0;
  endtask

  task automatic model_update(input logic [N-1:0] req, input logic rel_in);
    int w;
    bit fire;
    bit rel;
    fire   = 0;
    m_wdog = 0;
`ifdef RR_ARB_WATCHDOG_EN
    begin
      bit dropped;
      dropped = m_locked && !req[m_grant] && !rel_in;
      fire    = dropped && (m_cnt == WDOG - 1);
      m_cnt   = (dropped && !fire) ? m_cnt + 1 : 0;
      m_wdog  = fire;
    end
`endif
    rel = m_locked && (rel_in || fire);
    if (!m_locked) begin
      w = pick(req, m_ptr, -1);
      if (w >= 0) begin
        m_locked = 1;
        m_grant  = w;
      end
    end else if (rel) begin
      m_ptr = (m_grant + 1) % N;
      w = pick(req, m_ptr, m_grant);
      if (w >= 0) m_grant = w;
      else        m_locked = 0;
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [N-1:0] exp_oh;
    exp_oh = m_locked ? N'(1) << m_grant : '0;
    chk({tag, "_valid"}, 32'(bus.grant_valid_o), 32'(m_locked));
    chk({tag, "_grant"}, 32'(bus.grant_o), m_locked ? 32'(m_grant) : 32'd0);
    chk({tag, "_oh"}, 32'(bus.grant_oh_o), 32'(exp_oh));
    chk({tag, "_wdog"}, 32'(bus.wdog_o), 32'(m_wdog));
  endtask

  task automatic step(input string tag, input logic [N-1:0] req, input logic rel);
    bus.req_i     = req;
    bus.release_i = rel;
    model_update(req, rel);
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic do_reset();
    bus.req_i     = '0;
    bus.release_i = 1'b0;
    rst_n         = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    compare_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] rreq;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_i     = '0;
    bus.release_i = 1'b0;
    model_reset();
    #2;
    compare_outputs("por");
    do_reset();

    // Single grant from two requesters, ptr stays 0 while locked
    step("t1", 5'b10100, 1'b0);
    chk("t1_grant_fixed", 32'(bus.grant_o), 32'd2);
    chk("t1_oh_fixed", 32'(bus.grant_oh_o), 32'b00100);
    step("t1h", 5'b10100, 1'b0);
    step("t1r", 5'b10100, 1'b1);
    chk("t1_next_fixed", 32'(bus.grant_o), 32'd4);

    // Full contention, release every 3rd locked cycle
    do_reset();
    step("t2", 5'b11111, 1'b0);
    chk("t2_first", 32'(bus.grant_o), 32'd0);
    for (int g = 0; g < 5; g++) begin
      step("t2a", 5'b11111, 1'b0);
      step("t2b", 5'b11111, 1'b0);
      step("t2r", 5'b11111, 1'b1);
      chk("t2_seq", 32'(bus.grant_o), 32'((g + 1) % 5));
      chk("t2_nobubble", 32'(bus.grant_valid_o), 32'd1);
    end

    // Lone requester at the top index: idle one cycle, regrant, ptr wraps to 0
    do_reset();
    step("t3", 5'b10000, 1'b0);
    chk("t3_grant4", 32'(bus.grant_o), 32'd4);
    step("t3r", 5'b10000, 1'b1);
    chk("t3_idle", 32'(bus.grant_valid_o), 32'd0);
    step("t3g", 5'b10000, 1'b0);
    chk("t3_regrant", 32'(bus.grant_o), 32'd4);
    step("t3w", 5'b11111, 1'b1);
    chk("t3_wrap", 32'(bus.grant_o), 32'd0);

    // Asynchronous reset mid-packet
    do_reset();
    step("t4", 5'b01000, 1'b0);
    chk("t4_grant3", 32'(bus.grant_o), 32'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_outputs("t4_async");
    #1;
    rst_n = 1'b1;
    step("t4b", 5'b01000, 1'b0);
    chk("t4_regrant3", 32'(bus.grant_o), 32'd3);

    // Release while idle is ignored
    do_reset();
    step("t5", 5'b00000, 1'b1);
    step("t5g", 5'b00010, 1'b0);
    chk("t5_grant1", 32'(bus.grant_o), 32'd1);
    step("t5r", 5'b11111, 1'b1);
    chk("t5_ptr", 32'(bus.grant_o), 32'd2);

    // Dropped request on a held grant
    do_reset();
    step("t6", 5'b00010, 1'b0);
`ifdef RR_ARB_WATCHDOG_EN
    for (int c = 0; c < WDOG; c++) step("t6w", 5'b00100, 1'b0);
    chk("t6_wdog", 32'(bus.wdog_o), 32'd1);
    chk("t6_grant2", 32'(bus.grant_o), 32'd2);
    step("t6p", 5'b00100, 1'b0);
    chk("t6_pulse", 32'(bus.wdog_o), 32'd0);
`else
    for (int c = 0; c < 50; c++) step("t6h", 5'b00100, 1'b0);
    chk("t6_held", 32'(bus.grant_o), 32'd1);
`endif

    // Random traffic
    do_reset();
    rreq = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) rreq = N'($urandom);
      step("rnd", rreq, ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
